// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
//   Test-pattern generator for the 640x480 VGA path. Takes the visible-area
//   flag and raw sync counters from the sync generator and produces an RGB332
//   pixel one clock later. Eight patterns are selectable: horizontal/vertical
//   stripes, checkerboard, 8-bar colour bars, scrolling horizontal/vertical
//   stripes, diagonal stripes and solid white. The pattern request is only
//   taken at frame start so a change never tears a frame.
//
// Ports
//   clk       in   1   pixel clock
//   clr       in   1   asynchronous active-high reset
//   vidon     in   1   visible-area flag
//   hc        in   10  horizontal counter
//   vc        in   10  vertical counter
//   mode_sel  in   3   requested pattern, sampled when hc==0 && vc==0
//   red       out  3   red intensity   (registered)
//   green     out  3   green intensity (registered)
//   blue      out  2   blue intensity  (registered)
// -----------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int HBP         = 144,
    parameter int VBP         = 31,
    parameter int STRIPE_LOG2 = 4,
    parameter int BAR_W       = 80,
    parameter int SCROLL_DIV  = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       vidon,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic [2:0] mode_sel,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int PX_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [9:0]       HBP_V    = 10'(HBP);
    localparam logic [9:0]       VBP_V    = 10'(VBP);
    localparam logic [PX_W-1:0]  BAR_LAST = PX_W'(BAR_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    // Picks the stripe-select bit (bit STRIPE_LOG2) out of a 10-bit coordinate.
    function automatic logic sel_bit(input logic [9:0] v);
        return (((v >> STRIPE_LOG2) & 10'd1) != 10'd0);
    endfunction

    // Stripe colouring: red when the select bit is set, green otherwise.
    function automatic logic [7:0] stripe_rgb(input logic s);
        return {{3{s}}, {3{~s}}, 2'b00};
    endfunction

    logic [2:0]       mode_q,       mode_d;
    logic [9:0]       scroll_off_q, scroll_off_d;
    logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
    logic [PX_W-1:0]  bar_px_q,     bar_px_d;
    logic [2:0]       bar_idx_q,    bar_idx_d;
    logic [7:0]       pix_q,        pix_d;

    logic       frame_tick_s;
    logic [9:0] x_s;
    logic [9:0] y_s;

    // Frame-synchronous state: pattern latch and scroll divider/offset.
    always_comb begin
        frame_tick_s = (hc == 10'd0) && (vc == 10'd0);
        mode_d       = mode_q;
        scroll_off_d = scroll_off_q;
        div_cnt_d    = div_cnt_q;
        if (frame_tick_s) begin
            mode_d = mode_sel;
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d    = '0;
                scroll_off_d = scroll_off_q + 10'd1;
            end else begin
                div_cnt_d    = div_cnt_q + DIV_W'(1);
            end
        end else begin
            mode_d = mode_q;
        end
    end

    // Colour-bar position: restarts every visible run, index saturates at the last bar.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (!vidon) begin
            bar_px_d  = '0;
            bar_idx_d = 3'd0;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            if (bar_idx_q == 3'd7) begin
                bar_idx_d = 3'd7;
            end else begin
                bar_idx_d = bar_idx_q + 3'd1;
            end
        end else begin
            bar_px_d  = bar_px_q + PX_W'(1);
        end
    end

    // Pixel colour for the current inputs; uses the mode/offset/bar state before this edge updates them.
    always_comb begin
        x_s   = hc - HBP_V;
        y_s   = vc - VBP_V;
        pix_d = 8'h00;
        if (vidon) begin
            case (mode_q)
                3'd0:    pix_d = stripe_rgb(sel_bit(y_s));
                3'd1:    pix_d = stripe_rgb(sel_bit(x_s));
                3'd2:    pix_d = (sel_bit(x_s) ^ sel_bit(y_s)) ? 8'hFF : 8'h00;
                3'd3:    pix_d = {{3{~bar_idx_q[1]}}, {3{~bar_idx_q[2]}}, {2{~bar_idx_q[0]}}};
                3'd4:    pix_d = stripe_rgb(sel_bit(y_s + scroll_off_q));
                3'd5:    pix_d = stripe_rgb(sel_bit(x_s + scroll_off_q));
                3'd6:    pix_d = stripe_rgb(sel_bit(x_s + y_s));
                3'd7:    pix_d = 8'hFF;
                default: pix_d = 8'h00;
            endcase
        end else begin
            pix_d = 8'h00;
        end
    end

    // State and output registers; clr clears everything, including over a coincident frame tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_q       <= 3'd0;
            scroll_off_q <= 10'd0;
            div_cnt_q    <= '0;
            bar_px_q     <= '0;
            bar_idx_q    <= 3'd0;
            pix_q        <= 8'h00;
        end else begin
            mode_q       <= mode_d;
            scroll_off_q <= scroll_off_d;
            div_cnt_q    <= div_cnt_d;
            bar_px_q     <= bar_px_d;
            bar_idx_q    <= bar_idx_d;
            pix_q        <= pix_d;
        end
    end

    assign red   = pix_q[7:5];
    assign green = pix_q[4:2];
    assign blue  = pix_q[1:0];

endmodule
